mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port unified memory between the instruction-fetch port and the load/store data port of the RV32I core. It arbitrates between the two requesters and sequences each memory transaction through a valid/ready handshake. Each transaction's result is returned as a one-cycle registered response. It also drives a pipeline stall and flags transactions that the memory never completes. It sits between the core's PC/fetch and data paths and the memory model.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width
- MAX_D_STREAK, 4, max consecutive data grants while fetch is waiting (≥1)
- TIMEOUT, 255, cycles to wait for mem_ready_i before abort; 0 disables timeout

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request; held until if_valid_o
- if_addr_i  in  ADDR_WIDTH  fetch address (PC)
- if_valid_o  out  1  one-cycle fetch response pulse
- if_rdata_o  out  DATA_WIDTH  fetched instruction; meaningful while if_valid_o=1
- d_req_i  in  1  data request; held until d_valid_o
- d_we_i  in  1  1=store, 0=load
- d_addr_i  in  ADDR_WIDTH  data address
- d_wdata_i  in  DATA_WIDTH  store data
- d_be_i  in  DATA_WIDTH/8  store byte enables
- d_valid_o  out  1  one-cycle data response pulse
- d_rdata_o  out  DATA_WIDTH  load data; meaningful while d_valid_o=1
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_be_o  out  DATA_WIDTH/8  memory byte enables
- mem_rdata_i  in  DATA_WIDTH  memory read data; valid when mem_ready_i=1
- mem_ready_i  in  1  memory completes the current request this cycle
- stall_o  out  1  pipeline stall (combinational)
- err_o  out  1  one-cycle pulse with valid_o when a transaction timed out

## Operation
- FSM states: IDLE, IF_BUSY, D_BUSY.
- IDLE arbitration uses masked requests:
  - if_req_i & ~if_valid_o
  - d_req_i & ~d_valid_o
  - A request arriving in the same cycle as its own valid pulse is therefore ignored.
- Arbitration in IDLE:
  - Only one request pending: grant it.
  - Both pending: data wins, unless the streak counter equals MAX_D_STREAK; then fetch wins.
  - On grant, latch address, we, wdata and be into internal registers. Fetch latches we=0, be=all ones.
  - Next state is IF_BUSY or D_BUSY.
- Streak counter (width $clog2(MAX_D_STREAK+1)):
  - +1 on each data grant made while fetch is pending. Saturates at MAX_D_STREAK.
  - Cleared on any fetch grant.
  - Cleared on a data grant made with fetch not pending.
- BUSY states:
  - mem_req_o=1 and mem_* driven from the latched registers. Registers stay stable until completion.
  - Completion is mem_req_o & mem_ready_i.
  - On completion, register mem_rdata_i into the granted port's rdata_o, pulse that port's valid_o next cycle, and return to IDLE.
- Wait counter:
  - Cleared on grant; increments each BUSY cycle without mem_ready_i.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT:
    - Abort and return to IDLE; mem_req_o drops the following cycle.
    - Pulse valid_o of the granted port with rdata_o=0 and err_o=1.
- stall_o = (if_req_i & ~if_valid_o) | (d_req_i & ~d_valid_o).
- Responses are never reordered. At most one transaction is outstanding.
- Requesters must keep req and payload stable until their valid pulse. Behaviour with a request withdrawn early is undefined.

## Timing
- Reset (rst_n=0, immediate):
  - State IDLE; all outputs 0, including mem_req_o, valid_o, rdata_o and err_o.
  - Streak and wait counters 0.
  - mem_req_o drops asynchronously; any in-flight transaction is discarded and not responded to.
- Minimum latency, request to valid, with mem_ready_i tied high:
  - Cycle 0: req seen in IDLE.
  - Cycle 1: mem_req_o=1, ready=1.
  - Cycle 2: valid_o=1.
- Back-to-back throughput: one transaction per 2 cycles. The cycle of a valid pulse is IDLE and may grant the other requester.
- Each extra cycle of mem_ready_i low adds one cycle of latency.
- Simultaneous requests in IDLE follow the arbitration rule. A new request arriving during BUSY waits for IDLE.
- Timeout with TIMEOUT=T: grant in cycle 0, mem_req_o high in cycles 1..T. The abort edge is at the end of cycle T. valid_o=1 and err_o=1 in cycle T+1.
- mem_ready_i while mem_req_o=0 is ignored.

## Test plan
- Single fetch:
  - Stimulus: if_addr_i=0x0000_0010, memory returns 0x00500093 with ready high.
  - Required: mem_req_o in cycle 1; if_valid_o=1, if_rdata_o=0x00500093 in cycle 2; stall_o high in cycles 0–1 only.
- Simultaneous requests:
  - Stimulus: fetch and store (d_addr_i=0x100, d_wdata_i=0xDEADBEEF, d_be_i=4'b0011) asserted together.
  - Required: store issued first with mem_we_o=1 and mem_be_o=0011; d_valid_o in cycle 2; fetch granted in cycle 2; if_valid_o in cycle 4.
- Starvation guard:
  - Stimulus: MAX_D_STREAK=4, fetch held high, continuous back-to-back loads.
  - Required: exactly 4 data grants, then a fetch grant; the counter restarts afterwards.
- Wait states:
  - Stimulus: mem_ready_i low for 3 cycles on a load.
  - Required: mem_addr_o and mem_we_o stable throughout; d_valid_o 5 cycles after the request.
- Timeout:
  - Stimulus: TIMEOUT=8, mem_ready_i held low.
  - Required: mem_req_o high for 8 cycles; then d_valid_o=1, err_o=1, d_rdata_o=0; FSM back in IDLE.
- Reset mid-transaction:
  - Stimulus: rst_n low during D_BUSY.
  - Required: mem_req_o and all valid_o low immediately; no response after release; the re-asserted request is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates the RV32I fetch and load/store ports onto one single-port memory,
// one outstanding transaction at a time, with a fetch starvation guard and a wait timeout.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_valid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  output logic                    d_valid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_ready_i,
  output logic                    stall_o,
  output logic                    err_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned SW       = $clog2(MAX_D_STREAK + 1);
  localparam int unsigned WW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    D_BUSY
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]     be_q, be_d;
  logic [SW-1:0]           streak_q, streak_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic [WW-1:0]           wait_inc;
  logic                    if_valid_d, d_valid_d, err_d;
  logic [DATA_WIDTH-1:0]   if_rdata_d, d_rdata_d;
  logic                    if_pend, d_pend, busy, abort;

  // A request seen in the same cycle as its own response pulse is the old one.
  assign if_pend  = if_req_i & ~if_valid_o;
  assign d_pend   = d_req_i & ~d_valid_o;
  assign busy     = (state_q != IDLE);
  assign wait_inc = wait_q + 1'b1;
  assign abort    = (TIMEOUT != 0) && busy && !mem_ready_i && (wait_inc == WAIT_LIMIT);

  assign stall_o     = if_pend | d_pend;
  assign mem_req_o   = busy;
  assign mem_we_o    = busy & we_q;
  assign mem_addr_o  = busy ? addr_q  : '0;
  assign mem_wdata_o = busy ? wdata_q : '0;
  assign mem_be_o    = busy ? be_q    : '0;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    streak_d   = streak_q;
    wait_d     = wait_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata_o;
    d_rdata_d  = d_rdata_o;

    case (state_q)
      IDLE: begin
        if (d_pend && (!if_pend || streak_q != STREAK_MAX)) begin
          state_d = D_BUSY;
          addr_d  = d_addr_i;
          we_d    = d_we_i;
          wdata_d = d_wdata_i;
          be_d    = d_be_i;
          wait_d  = '0;
          // With fetch waiting the streak is below its cap here, so it cannot overflow.
          streak_d = if_pend ? streak_q + 1'b1 : '0;
        end else if (if_pend) begin
          state_d  = IF_BUSY;
          addr_d   = if_addr_i;
          we_d     = 1'b0;
          wdata_d  = '0;
          be_d     = '1;
          wait_d   = '0;
          streak_d = '0;
        end
      end

      IF_BUSY, D_BUSY: begin
        if (mem_ready_i) begin
          state_d = IDLE;
          if (state_q == IF_BUSY) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata_i;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = mem_rdata_i;
          end
        end else if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
          if (state_q == IF_BUSY) begin
            if_valid_d = 1'b1;
            if_rdata_d = '0;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          wait_d = wait_inc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      streak_q   <= '0;
      wait_q     <= '0;
      if_valid_o <= 1'b0;
      if_rdata_o <= '0;
      d_valid_o  <= 1'b0;
      d_rdata_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      streak_q   <= streak_d;
      wait_q     <= wait_d;
      if_valid_o <= if_valid_d;
      if_rdata_o <= if_rdata_d;
      d_valid_o  <= d_valid_d;
      d_rdata_o  <= d_rdata_d;
      err_o      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXS = 4;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_i, if_valid_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i, d_we_i, d_valid_o;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i, d_rdata_o;
  logic [BW-1:0] d_be_i;
  logic          mem_req_o, mem_we_o, mem_ready_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic [BW-1:0] mem_be_o;
  logic          stall_o, err_o;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MAX_D_STREAK(MAXS),
    .TIMEOUT     (TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_be_i(d_be_i),
    .d_valid_o(d_valid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the one outstanding transaction and the pending response.
  bit            busy;
  bit            cur_is_d;
  logic [AW-1:0] cur_addr;
  logic          cur_we;
  logic [DW-1:0] cur_wdata;
  logic [BW-1:0] cur_be;
  int            cur_age;
  int            d_run;       // data grants in a row taken while fetch waited
  bit            rv_if, rv_d, r_err;
  logic [DW-1:0] r_if_data, r_d_data;
  int            lowrun = 0;

  task automatic model_reset();
    busy = 0; cur_age = 0; d_run = 0;
    rv_if = 0; rv_d = 0; r_err = 0;
    r_if_data = '0; r_d_data = '0;
  endtask

  task automatic advance();
    bit if_p, d_p, n_if, n_d, n_err;
    logic [DW-1:0] n_data;
    if_p = if_req_i && !rv_if;
    d_p  = d_req_i && !rv_d;
    n_if = 0; n_d = 0; n_err = 0; n_data = '0;
    if (busy) begin
      cur_age++;
      if (mem_ready_i) begin
        n_data = mem_rdata_i;
        if (cur_is_d) n_d = 1; else n_if = 1;
        busy = 0;
      end else if (TO != 0 && cur_age == TO) begin
        n_err = 1;
        if (cur_is_d) n_d = 1; else n_if = 1;
        busy = 0;
      end
    end else if (if_p || d_p) begin
      busy = 1; cur_age = 0;
      if (d_p && (!if_p || d_run < MAXS)) begin
        cur_is_d = 1; cur_addr = d_addr_i; cur_we = d_we_i; cur_wdata = d_wdata_i; cur_be = d_be_i;
        d_run = if_p ? d_run + 1 : 0;
      end else begin
        cur_is_d = 0; cur_addr = if_addr_i; cur_we = 0; cur_wdata = '0; cur_be = '1;
        d_run = 0;
      end
    end
    rv_if = n_if; rv_d = n_d; r_err = n_err;
    if (n_if) r_if_data = n_data;
    if (n_d)  r_d_data  = n_data;
  endtask

  task automatic evaluate();
    #1;
    if (!rst_n) begin
      model_reset();
      check("rst_mem_req", mem_req_o, 0);
      check("rst_if_valid", if_valid_o, 0);
      check("rst_d_valid", d_valid_o, 0);
      check("rst_err", err_o, 0);
      check("rst_if_rdata", if_rdata_o, 0);
      check("rst_d_rdata", d_rdata_o, 0);
      return;
    end
    check("mem_req", mem_req_o, busy);
    if (busy) begin
      check("mem_addr", mem_addr_o, cur_addr);
      check("mem_we", mem_we_o, cur_we);
      check("mem_be", mem_be_o, cur_be);
      if (cur_we) check("mem_wdata", mem_wdata_o, cur_wdata);
    end
    check("stall", stall_o, (if_req_i && !rv_if) || (d_req_i && !rv_d));
    check("if_valid", if_valid_o, rv_if);
    if (rv_if) check("if_rdata", if_rdata_o, r_if_data);
    check("d_valid", d_valid_o, rv_d);
    if (rv_d) check("d_rdata", d_rdata_o, r_d_data);
    check("err", err_o, r_err);
    advance();
  endtask

  // Requests are held until their response pulse, then released.
  task automatic next_cycle();
    @(negedge clk);
    if (if_req_i && rv_if) if_req_i = 0;
    if (d_req_i && rv_d) d_req_i = 0;
  endtask

  task automatic new_load(input logic [AW-1:0] a);
    d_req_i = 1; d_we_i = 0; d_addr_i = a; d_wdata_i = $urandom; d_be_i = 4'hF;
  endtask

  initial begin
    rst_n = 0; model_reset();
    if_req_i = 0; if_addr_i = '0;
    d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
    mem_ready_i = 0; mem_rdata_i = '0;
    @(negedge clk); evaluate();
    next_cycle(); rst_n = 1; evaluate();

    // single fetch
    next_cycle(); if_req_i = 1; if_addr_i = 32'h0000_0010; mem_ready_i = 1; mem_rdata_i = 32'h0050_0093;
    evaluate();
    repeat (3) begin next_cycle(); evaluate(); end

    // simultaneous fetch and store
    next_cycle();
    if_req_i = 1; if_addr_i = 32'h0000_0014;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'b0011;
    evaluate();
    repeat (6) begin next_cycle(); mem_rdata_i = $urandom; evaluate(); end

    // fetch held against continuous loads
    for (int unsigned i = 0; i < 24; i++) begin
      next_cycle();
      if (!if_req_i) begin if_req_i = 1; if_addr_i = $urandom & ~32'h3; end
      if (!d_req_i) new_load($urandom & ~32'h3);
      mem_ready_i = 1; mem_rdata_i = $urandom;
      evaluate();
    end
    for (int unsigned i = 0; i < 6; i++) begin next_cycle(); evaluate(); end

    // wait states: ready low for three cycles
    next_cycle(); new_load(32'h240); mem_ready_i = 0; evaluate();
    for (int unsigned i = 1; i <= 6; i++) begin
      next_cycle(); mem_ready_i = (i >= 4); mem_rdata_i = $urandom; evaluate();
    end

    // timeout with ready held low
    next_cycle(); new_load(32'h300); mem_ready_i = 0; evaluate();
    repeat (12) begin next_cycle(); evaluate(); end

    // reset in the middle of a data transaction
    next_cycle(); new_load(32'h400); mem_ready_i = 0; evaluate();
    repeat (2) begin next_cycle(); evaluate(); end
    next_cycle(); rst_n = 0; evaluate();
    next_cycle(); rst_n = 1; mem_ready_i = 1; mem_rdata_i = 32'h1234_5678; evaluate();
    repeat (4) begin next_cycle(); evaluate(); end

    // random traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      next_cycle();
      if (!if_req_i && $urandom_range(0, 2) == 0) begin
        if_req_i = 1; if_addr_i = $urandom & ~32'h3;
      end
      if (!d_req_i && $urandom_range(0, 2) == 0) begin
        d_req_i = 1; d_we_i = 1'($urandom_range(0, 1)); d_addr_i = $urandom & ~32'h3;
        d_wdata_i = $urandom; d_be_i = 4'($urandom_range(0, 15));
      end
      if (lowrun > 0) begin
        mem_ready_i = 0; lowrun--;
      end else begin
        if ($urandom_range(0, 49) == 0) lowrun = $urandom_range(5, 12);
        mem_ready_i = ($urandom_range(0, 3) != 0);
      end
      mem_rdata_i = $urandom;
      evaluate();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
